// File: rtl/mem_dcache_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_dcache_arbiter_pkg
// Shared types for the mem-stage dcache arbiter slice.
//   mem_arb_state_t : arbiter FSM state encoding
//   mem_req_t       : one latched memory request {is_store, addr, wdata, wstrb}
//   state_pauses()  : states in which the mem stage is held unconditionally
//   sat_inc()       : saturating 32-bit increment for the optional perf counters
// The struct widths are the default ADDR_WIDTH/DATA_WIDTH of the arbiter.
// -----------------------------------------------------------------------------
package mem_dcache_arbiter_pkg;

   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_DATA_WIDTH = 32;
   localparam int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      DONE  = 3'd5,
      DRAIN = 3'd6
   } mem_arb_state_t;

   typedef struct packed {
      logic                      is_store;
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [MEM_DATA_WIDTH-1:0] wdata;
      logic [MEM_STRB_WIDTH-1:0] wstrb;
   } mem_req_t;

   function automatic logic state_pauses(input mem_arb_state_t s);
      return (s == REQ0) || (s == WAIT0) || (s == REQ1) || (s == WAIT1) || (s == DRAIN);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mem_dcache_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_dcache_arbiter_if
// Request/response bus between the arbiter (master) and the dcache (slave).
//   valid    : request valid            (master -> slave)
//   op       : 1 = write                (master -> slave)
//   addr     : request address          (master -> slave)
//   wdata    : store data               (master -> slave)
//   wstrb    : byte strobes             (master -> slave)
//   addr_ok  : request accepted         (slave -> master)
//   data_ok  : load data / store done   (slave -> master)
//   rdata    : load data                (slave -> master)
// -----------------------------------------------------------------------------
interface mem_dcache_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    valid;
   logic                    op;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    addr_ok;
   logic                    data_ok;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (
      output valid, op, addr, wdata, wstrb,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  valid, op, addr, wdata, wstrb,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_dcache_arbiter_slot_buf.sv
// -----------------------------------------------------------------------------
// mem_req_slot_buf
// Holds one mem-stage slot's request for the duration of an arbitration round,
// plus that slot's response data and completion flag.
//   clk, rst  : clock, asynchronous active-low reset
//   latch_en  : capture req_in, clear rdata/done (start of a round)
//   req_in    : live request fields from the ex/mem register
//   resp_en   : dcache response for this slot is being accepted
//   resp_data : dcache read data
//   req       : latched request
//   rdata     : latched load data (stays 0 for stores)
//   done      : access completed in this round
// -----------------------------------------------------------------------------
module mem_req_slot_buf
   import mem_dcache_arbiter_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      latch_en,
   input  mem_req_t                  req_in,
   input  logic                      resp_en,
   input  logic [MEM_DATA_WIDTH-1:0] resp_data,
   output mem_req_t                  req,
   output logic [MEM_DATA_WIDTH-1:0] rdata,
   output logic                      done
);

   mem_req_t                  req_reg;
   logic [MEM_DATA_WIDTH-1:0] rdata_reg;
   logic                      done_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_reg   <= '0;
         rdata_reg <= '0;
         done_reg  <= 1'b0;
      end else if (latch_en) begin
         req_reg   <= req_in;
         rdata_reg <= '0;
         done_reg  <= 1'b0;
      end else if (resp_en) begin
         done_reg <= 1'b1;
         if (!req_reg.is_store) begin
            rdata_reg <= resp_data;
         end
      end
   end

   assign req   = req_reg;
   assign rdata = rdata_reg;
   assign done  = done_reg;

endmodule

// File: rtl/mem_dcache_arbiter.sv
// -----------------------------------------------------------------------------
// mem_dcache_arbiter
// Serialises the two memory ops of the dual-issue mem stage onto the single
// dcache port in program order (slot 0, then slot 1), holds the mem stage via
// pause_mem while the round is in flight, and latches per-slot results.
//   clk, rst        : clock, asynchronous active-low reset (shared with dcache)
//   flush           : pipeline redirect; abandons or drains the current round
//   slot_mem_valid  : slot i carries a load/store
//   slot_is_store   : 1 = store, 0 = load
//   slot_exception  : slot i already excepted (slot 0 exception also kills 1)
//   slot_addr/wdata/wstrb : per-slot request fields
//   dc              : dcache bus (mem_dcache_arbiter_if.master)
//   slot_rdata      : latched load data per slot
//   slot_done       : per-slot completion, valid through DONE
//   pause_mem       : stall request to the pipeline controller
// Optional build macro MEM_ARB_PERF_EN adds saturating 32-bit counters
// perf_req_cnt, perf_stall_cnt and perf_dual_cnt.
// -----------------------------------------------------------------------------
module mem_dcache_arbiter
   import mem_dcache_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [1:0]                   slot_mem_valid,
   input  logic [1:0]                   slot_is_store,
   input  logic [1:0]                   slot_exception,
   input  logic [1:0][ADDR_WIDTH-1:0]   slot_addr,
   input  logic [1:0][DATA_WIDTH-1:0]   slot_wdata,
   input  logic [1:0][DATA_WIDTH/8-1:0] slot_wstrb,
   mem_dcache_arbiter_if.master         dc,
   output logic [1:0][DATA_WIDTH-1:0]   slot_rdata,
   output logic [1:0]                   slot_done,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]                  perf_req_cnt,
   output logic [31:0]                  perf_stall_cnt,
   output logic [31:0]                  perf_dual_cnt,
`endif
   output logic                         pause_mem
);

   mem_arb_state_t            state_reg;
   logic                      dc_valid_reg;
   logic                      elig1_reg;
   logic [1:0]                elig;
   logic                      start;
   logic                      sel1;
   mem_req_t [1:0]            req_in;
   mem_req_t [1:0]            req_q;
   logic [1:0][DATA_WIDTH-1:0] rdata_q;
   logic [1:0]                done_q;
   logic [1:0]                resp_en;

   // An excepting slot 0 squashes slot 1 as well: it is younger in program order.
   assign elig[0] = slot_mem_valid[0] & ~slot_exception[0];
   assign elig[1] = slot_mem_valid[1] & ~slot_exception[1] & ~slot_exception[0];

   assign start = (state_reg == IDLE) && !flush && (|elig);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         localparam mem_arb_state_t WAIT_ST = (gi == 0) ? WAIT0 : WAIT1;

         assign req_in[gi] = '{is_store: slot_is_store[gi],
                               addr:     slot_addr[gi],
                               wdata:    slot_wdata[gi],
                               wstrb:    slot_wstrb[gi]};

         // A response that coincides with a flush belongs to squashed work.
         assign resp_en[gi] = dc.data_ok && !flush && (state_reg == WAIT_ST);

         mem_req_slot_buf u_buf (
            .clk       (clk),
            .rst       (rst),
            .latch_en  (start),
            .req_in    (req_in[gi]),
            .resp_en   (resp_en[gi]),
            .resp_data (dc.rdata),
            .req       (req_q[gi]),
            .rdata     (rdata_q[gi]),
            .done      (done_q[gi])
         );

         assign slot_rdata[gi] = rdata_q[gi];
         assign slot_done[gi]  = done_q[gi];
      end
   endgenerate

   // Request fields come straight from the latched buffers, so they cannot
   // change while a request waits for addr_ok.
   assign sel1     = (state_reg == REQ1);
   assign dc.valid = dc_valid_reg;
   assign dc.op    = sel1 ? req_q[1].is_store : req_q[0].is_store;
   assign dc.addr  = sel1 ? req_q[1].addr     : req_q[0].addr;
   assign dc.wdata = sel1 ? req_q[1].wdata    : req_q[0].wdata;
   assign dc.wstrb = sel1 ? req_q[1].wstrb    : req_q[0].wstrb;

   // In IDLE the stall must be raised in the same cycle the slots are seen.
   assign pause_mem = state_pauses(state_reg) | start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         dc_valid_reg <= 1'b0;
         elig1_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  elig1_reg    <= elig[1];
                  dc_valid_reg <= 1'b1;
                  state_reg    <= elig[0] ? REQ0 : REQ1;
               end
            end
            REQ0, REQ1: begin
               if (dc.addr_ok) begin
                  dc_valid_reg <= 1'b0;
                  if (flush)                  state_reg <= DRAIN;
                  else if (state_reg == REQ0) state_reg <= WAIT0;
                  else                        state_reg <= WAIT1;
               end else if (flush) begin
                  dc_valid_reg <= 1'b0;
                  state_reg    <= IDLE;
               end
            end
            WAIT0: begin
               if (dc.data_ok) begin
                  // Flush with the response in hand: nothing left to drain.
                  if (flush) begin
                     state_reg <= IDLE;
                  end else if (elig1_reg) begin
                     dc_valid_reg <= 1'b1;
                     state_reg    <= REQ1;
                  end else begin
                     state_reg <= DONE;
                  end
               end else if (flush) begin
                  state_reg <= DRAIN;
               end
            end
            WAIT1: begin
               if (dc.data_ok)  state_reg <= flush ? IDLE : DONE;
               else if (flush)  state_reg <= DRAIN;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            DRAIN: begin
               if (dc.data_ok) state_reg <= IDLE;
            end
            default: begin
               dc_valid_reg <= 1'b0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_req_reg;
   logic [31:0] perf_stall_reg;
   logic [31:0] perf_dual_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_req_reg   <= '0;
         perf_stall_reg <= '0;
         perf_dual_reg  <= '0;
      end else begin
         if (dc_valid_reg && dc.addr_ok) perf_req_reg   <= sat_inc(perf_req_reg);
         if (pause_mem)                  perf_stall_reg <= sat_inc(perf_stall_reg);
         if (start && (&elig))           perf_dual_reg  <= sat_inc(perf_dual_reg);
      end
   end

   assign perf_req_cnt   = perf_req_reg;
   assign perf_stall_cnt = perf_stall_reg;
   assign perf_dual_cnt  = perf_dual_reg;
`endif

   // The dcache only answers a request it has accepted.
   data_ok_only_when_outstanding: assert property (
      @(posedge clk) disable iff (!rst)
      dc.data_ok |-> (state_reg == WAIT0 || state_reg == WAIT1 || state_reg == DRAIN)
   );

endmodule

// File: tb/tb_mem_dcache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_dcache_arbiter
// Directed bench for mem_dcache_arbiter. A small dcache responder inside tick()
// accepts requests after addr_wait cycles and answers data_delay cycles later.
// -----------------------------------------------------------------------------
module tb_mem_dcache_arbiter;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       slot_mem_valid = '0;
   logic [1:0]       slot_is_store = '0;
   logic [1:0]       slot_exception = '0;
   logic [1:0][31:0] slot_addr = '0;
   logic [1:0][31:0] slot_wdata = '0;
   logic [1:0][3:0]  slot_wstrb = '0;
   logic [1:0][31:0] slot_rdata;
   logic [1:0]       slot_done;
   logic             pause_mem;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]      perf_req_cnt;
   logic [31:0]      perf_stall_cnt;
   logic [31:0]      perf_dual_cnt;
`endif

   mem_dcache_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dc_bus ();

   mem_dcache_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .slot_mem_valid (slot_mem_valid),
      .slot_is_store  (slot_is_store),
      .slot_exception (slot_exception),
      .slot_addr      (slot_addr),
      .slot_wdata     (slot_wdata),
      .slot_wstrb     (slot_wstrb),
      .dc             (dc_bus),
      .slot_rdata     (slot_rdata),
      .slot_done      (slot_done),
`ifdef MEM_ARB_PERF_EN
      .perf_req_cnt   (perf_req_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_dual_cnt  (perf_dual_cnt),
`endif
      .pause_mem      (pause_mem)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          addr_wait = 0;
   int          data_delay = 1;
   int          wait_cnt = 0;
   int          data_cnt = 0;
   logic [31:0] pend_rdata = '0;
   logic [31:0] acc_addr_q[$];
   logic        acc_op_q[$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      case (a)
         32'h0000_1000: return 32'hDEAD_BEEF;
         32'h0000_2004: return 32'h1234_5678;
         32'h0000_4000: return 32'h0A0B_0C0D;
         32'h0000_4004: return 32'h55AA_33CC;
         default:       return 32'h0BAD_F00D;
      endcase
   endfunction

   // Advance to the next negedge, play the dcache for the coming posedge.
   task automatic tick();
      @(negedge clk);
      dc_bus.addr_ok = 1'b0;
      dc_bus.data_ok = 1'b0;
      dc_bus.rdata   = '0;
      if (data_cnt > 0) begin
         data_cnt = data_cnt - 1;
         if (data_cnt == 0) begin
            dc_bus.data_ok = 1'b1;
            dc_bus.rdata   = pend_rdata;
         end
      end
      if (dc_bus.valid === 1'b1) begin
         if (wait_cnt >= addr_wait) begin
            dc_bus.addr_ok = 1'b1;
            wait_cnt       = 0;
            data_cnt       = data_delay;
            pend_rdata     = mem_data(dc_bus.addr);
            acc_addr_q.push_back(dc_bus.addr);
            acc_op_q.push_back(dc_bus.op);
         end else begin
            wait_cnt = wait_cnt + 1;
         end
      end
      #1;
   endtask

   task automatic reset_responder();
      wait_cnt   = 0;
      data_cnt   = 0;
      addr_wait  = 0;
      data_delay = 1;
      acc_addr_q.delete();
      acc_op_q.delete();
   endtask

   task automatic clear_slots();
      slot_mem_valid = '0;
      slot_is_store  = '0;
      slot_exception = '0;
      slot_addr      = '0;
      slot_wdata     = '0;
      slot_wstrb     = '0;
   endtask

   // Runs until the first low pause_mem after a high stretch (the DONE cycle).
   // total = cycle index of DONE counted from the current cycle.
   task automatic run_to_done(output int pause_cycles, output int total);
      bit done_seen;
      done_seen    = 1'b0;
      pause_cycles = 0;
      total        = -1;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         if (pause_mem === 1'b1) begin
            pause_cycles++;
         end else if (pause_cycles > 0) begin
            done_seen = 1'b1;
            total     = i;
         end
         if (!done_seen) tick();
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL run_to_done_timeout got pause_cycles=%0d want a DONE cycle within 40", pause_cycles);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (dc_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_dc_valid got %0b want 0", dc_bus.valid); end
      checks++;
      if (pause_mem !== 1'b0) begin errors++; $display("FAIL reset_pause got %0b want 0", pause_mem); end
      checks++;
      if (slot_done !== 2'b00) begin errors++; $display("FAIL reset_slot_done got %b want 00", slot_done); end
      checks++;
      if (slot_rdata !== 64'h0) begin errors++; $display("FAIL reset_slot_rdata got %h want 0", slot_rdata); end
      rst = 1'b1;
      tick();
      $display("test_reset: done");
   endtask

   task automatic test_single_load();
      int pc, tot;
      reset_responder();
      clear_slots();
      slot_mem_valid = 2'b01;
      slot_addr[0]   = 32'h0000_1000;
      #1;
      run_to_done(pc, tot);
      checks++;
      if (pc !== 3) begin errors++; $display("FAIL single_pause_high got %0d want 3", pc); end
      checks++;
      if (tot !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", tot); end
      checks++;
      if (slot_done !== 2'b01) begin errors++; $display("FAIL single_done got %b want 01", slot_done); end
      checks++;
      if (slot_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", slot_rdata[0]); end
      checks++;
      if (acc_addr_q.size() != 1) begin
         errors++; $display("FAIL single_req_count got %0d want 1", acc_addr_q.size());
      end else if (acc_addr_q[0] !== 32'h0000_1000 || acc_op_q[0] !== 1'b0) begin
         errors++; $display("FAIL single_req got addr=%h op=%0b want addr=00001000 op=0", acc_addr_q[0], acc_op_q[0]);
      end
      clear_slots();
      tick();
      checks++;
      if (pause_mem !== 1'b0) begin errors++; $display("FAIL single_idle_pause got %0b want 0", pause_mem); end
      checks++;
      if (slot_done !== 2'b01) begin errors++; $display("FAIL single_done_hold got %b want 01", slot_done); end
      $display("test_single_load: pause_cycles=%0d latency=%0d rdata=%h", pc, tot, slot_rdata[0]);
   endtask

   task automatic test_dual();
      int pc, tot;
      reset_responder();
      clear_slots();
      slot_mem_valid = 2'b11;
      slot_is_store  = 2'b01;
      slot_addr[0]   = 32'h0000_2000;
      slot_wdata[0]  = 32'h1122_3344;
      slot_wstrb[0]  = 4'hF;
      slot_addr[1]   = 32'h0000_2004;
      #1;
      run_to_done(pc, tot);
      checks++;
      if (tot !== 5) begin errors++; $display("FAIL dual_latency got %0d want 5", tot); end
      checks++;
      if (pc !== 5) begin errors++; $display("FAIL dual_pause_high got %0d want 5", pc); end
      checks++;
      if (acc_addr_q.size() != 2) begin
         errors++; $display("FAIL dual_req_count got %0d want 2", acc_addr_q.size());
      end else if (acc_addr_q[0] !== 32'h0000_2000 || acc_addr_q[1] !== 32'h0000_2004 ||
                   acc_op_q[0] !== 1'b1 || acc_op_q[1] !== 1'b0) begin
         errors++;
         $display("FAIL dual_order got %h/%0b then %h/%0b want 00002000/1 then 00002004/0",
                  acc_addr_q[0], acc_op_q[0], acc_addr_q[1], acc_op_q[1]);
      end
      checks++;
      if (slot_done !== 2'b11) begin errors++; $display("FAIL dual_done got %b want 11", slot_done); end
      checks++;
      if (slot_rdata[1] !== 32'h1234_5678) begin errors++; $display("FAIL dual_rdata1 got %h want 12345678", slot_rdata[1]); end
      checks++;
      if (slot_rdata[0] !== 32'h0) begin errors++; $display("FAIL dual_rdata0_store got %h want 0", slot_rdata[0]); end
      clear_slots();
      tick();
      $display("test_dual: latency=%0d requests=%0d done=%b", tot, acc_addr_q.size(), slot_done);
   endtask

   task automatic test_addr_hold();
      int reqc, pc, tot;
      reset_responder();
      addr_wait = 5;
      clear_slots();
      slot_mem_valid = 2'b01;
      slot_is_store  = 2'b01;
      slot_addr[0]   = 32'h0000_3000;
      slot_wdata[0]  = 32'hCAFE_F00D;
      slot_wstrb[0]  = 4'h3;
      #1;
      tick();
      reqc = 0;
      for (int i = 0; i < 20; i++) begin
         if (dc_bus.valid !== 1'b1) break;
         reqc++;
         checks++;
         if ({dc_bus.op, dc_bus.addr, dc_bus.wdata, dc_bus.wstrb} !== {1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h3}) begin
            errors++;
            $display("FAIL hold_fields cycle %0d got op=%0b addr=%h wdata=%h wstrb=%h want 1/00003000/cafef00d/3",
                     i, dc_bus.op, dc_bus.addr, dc_bus.wdata, dc_bus.wstrb);
         end
         tick();
      end
      checks++;
      if (reqc !== 6) begin errors++; $display("FAIL hold_req_cycles got %0d want 6", reqc); end
      run_to_done(pc, tot);
      checks++;
      if (slot_done !== 2'b01) begin errors++; $display("FAIL hold_done got %b want 01", slot_done); end
      checks++;
      if (slot_rdata[0] !== 32'h0) begin errors++; $display("FAIL hold_store_rdata got %h want 0", slot_rdata[0]); end
      clear_slots();
      tick();
      $display("test_addr_hold: req_cycles=%0d", reqc);
   endtask

   task automatic test_exception();
      reset_responder();
      clear_slots();
      slot_mem_valid = 2'b11;
      slot_exception = 2'b01;
      slot_addr[0]   = 32'h0000_5000;
      slot_addr[1]   = 32'h0000_5004;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pause_mem !== 1'b0 || dc_bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_quiet cycle %0d got pause=%0b valid=%0b want 0/0", i, pause_mem, dc_bus.valid);
         end
         tick();
      end
      checks++;
      if (acc_addr_q.size() != 0) begin errors++; $display("FAIL exc_requests got %0d want 0", acc_addr_q.size()); end
      clear_slots();
      tick();
      $display("test_exception: requests=%0d", acc_addr_q.size());
   endtask

   task automatic test_flush_drain();
      reset_responder();
      data_delay = 4;
      clear_slots();
      slot_mem_valid = 2'b01;
      slot_addr[0]   = 32'h0000_1000;
      #1;
      tick();   // REQ0, accepted
      tick();   // WAIT0
      checks++;
      if (pause_mem !== 1'b1 || dc_bus.valid !== 1'b0) begin
         errors++; $display("FAIL flush_wait0 got pause=%0b valid=%0b want 1/0", pause_mem, dc_bus.valid);
      end
      flush = 1'b1;
      clear_slots();
      tick();   // DRAIN
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pause_mem !== 1'b1 || dc_bus.valid !== 1'b0) begin
            errors++; $display("FAIL flush_drain cycle %0d got pause=%0b valid=%0b want 1/0", i, pause_mem, dc_bus.valid);
         end
         tick();   // last pass carries data_ok into DRAIN
      end
      checks++;
      if (pause_mem !== 1'b0) begin errors++; $display("FAIL flush_idle_pause got %0b want 0", pause_mem); end
      checks++;
      if (slot_done !== 2'b00) begin errors++; $display("FAIL flush_discard_done got %b want 00", slot_done); end
      checks++;
      if (slot_rdata[0] !== 32'h0) begin errors++; $display("FAIL flush_discard_rdata got %h want 0", slot_rdata[0]); end
      tick();
      data_delay = 1;
      $display("test_flush_drain: done=%b", slot_done);
   endtask

   task automatic test_reset_mid();
      int pc, tot;
      reset_responder();
      clear_slots();
      slot_mem_valid = 2'b11;
      slot_addr[0]   = 32'h0000_4000;
      slot_addr[1]   = 32'h0000_4004;
      #1;
      repeat (4) tick();   // REQ0, WAIT0, REQ1, WAIT1
      checks++;
      if (slot_done !== 2'b01 || pause_mem !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre got done=%b pause=%0b want 01/1", slot_done, pause_mem);
      end
      rst            = 1'b0;
      dc_bus.addr_ok = 1'b0;
      dc_bus.data_ok = 1'b0;
      data_cnt       = 0;
      clear_slots();
      #1;
      checks++;
      if ({dc_bus.valid, pause_mem, slot_done} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_ctrl got valid=%0b pause=%0b done=%b want 0/0/00", dc_bus.valid, pause_mem, slot_done);
      end
      checks++;
      if (slot_rdata !== 64'h0 || dc_bus.addr !== 32'h0) begin
         errors++; $display("FAIL rstmid_data got rdata=%h addr=%h want 0/0", slot_rdata, dc_bus.addr);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      reset_responder();
      slot_mem_valid = 2'b01;
      slot_addr[0]   = 32'h0000_1000;
      #1;
      run_to_done(pc, tot);
      checks++;
      if (tot !== 3 || slot_done !== 2'b01 || slot_rdata[0] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rstmid_after got latency=%0d done=%b rdata=%h want 3/01/deadbeef", tot, slot_done, slot_rdata[0]);
      end
      clear_slots();
      tick();
      $display("test_reset_mid: post-reset latency=%0d rdata=%h", tot, slot_rdata[0]);
   endtask

   initial begin
      dc_bus.addr_ok = 1'b0;
      dc_bus.data_ok = 1'b0;
      dc_bus.rdata   = '0;
      test_reset();
      test_single_load();
      test_dual();
      test_addr_hold();
      test_exception();
      test_flush_drain();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_dcache_arbiter.md
Name: mem_dcache_arbiter

Overview:
- Sequences the dual-issue mem stage's two memory ops onto the single dcache port, strictly in program order (slot 0 first, then slot 1).
- Holds each request until `addr_ok`, collects the response on `data_ok`, latches load data per slot and drives the mem-stage pause.
- Sits between the ex/mem pipeline register and the dcache; load data formatting (byte/half extract, sign-extend) stays in the mem stage.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  pipeline flush (exception/ertn/branch redirect)
- slot_mem_valid  in  2  slot i carries a load/store
- slot_is_store  in  2  1 = store, 0 = load
- slot_exception  in  2  slot i already flagged an exception
- slot_addr  in  2×ADDR_WIDTH  per-slot address
- slot_wdata  in  2×DATA_WIDTH  per-slot store data
- slot_wstrb  in  2×DATA_WIDTH/8  per-slot byte strobes
- dc_valid  out  1  request valid to dcache
- dc_op  out  1  1 = write
- dc_addr  out  ADDR_WIDTH  request address
- dc_wdata  out  DATA_WIDTH  request store data
- dc_wstrb  out  DATA_WIDTH/8  request strobes
- dc_addr_ok  in  1  request accepted
- dc_data_ok  in  1  response valid / store complete
- dc_rdata  in  DATA_WIDTH  load data
- slot_rdata  out  2×DATA_WIDTH  latched load data per slot
- slot_done  out  2  slot i access completed
- pause_mem  out  1  stall request to ctrl

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- Reset: state = IDLE; `dc_valid`, `slot_done`, `pause_mem` = 0; `slot_rdata` = 0.
- Slot i is "eligible" when `slot_mem_valid[i]` && !`slot_exception[i]`. Slot 1 is also ineligible when `slot_exception[0]` is set.

IDLE:
- No eligible slot: `pause_mem` = 0, stay in IDLE.
- Otherwise: `pause_mem` = 1 (combinational), latch all slot inputs, clear `slot_done`, go to REQ0 if slot 0 is eligible, else REQ1.

REQn:
- `dc_valid` = 1 with slot n's latched fields.
- All outputs are held stable until `dc_addr_ok`; then go to WAITn.

WAITn:
- `dc_valid` = 0.
- On `dc_data_ok`: set `slot_done[n]`; for loads, latch `dc_rdata` into `slot_rdata[n]`.
- Next state: REQ1 if n = 0 and slot 1 is eligible, else DONE.

DONE:
- `pause_mem` = 0 for exactly one cycle, so the pipeline advances; then return to IDLE.
- `slot_done` and `slot_rdata` stay valid through DONE and are cleared on the next latch.

`pause_mem` = 1 in REQ0, WAIT0, REQ1, WAIT1 and DRAIN.

Flush:
- In IDLE/REQn/DONE: go to IDLE next cycle; a REQn with no `addr_ok` is abandoned.
- In WAITn: go to DRAIN.
- If `addr_ok` coincides with flush in REQn: go to DRAIN.

DRAIN:
- Waits for the outstanding `dc_data_ok`, discards it, then goes to IDLE.
- No new request is issued while in DRAIN.

Dcache contract:
- `dc_data_ok` is never asserted in the same cycle as its `dc_addr_ok`.
- At most one request is outstanding.
- A `dc_data_ok` seen in IDLE/REQn/DONE is a protocol error (assertion).

Latency, both hits with `data_ok` one cycle after `addr_ok`:
- One op: 4 cycles from IDLE to DONE.
- Two ops: 6 cycles.

Asynchronous reset mid-transaction returns to IDLE immediately; the dcache is reset by the same `rst`.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds 32-bit output counters:
  - `perf_req_cnt` (+1 per `addr_ok`)
  - `perf_stall_cnt` (+1 per cycle `pause_mem` = 1)
  - `perf_dual_cnt` (+1 per IDLE latch with both slots eligible)
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist and function is identical.

Decomposition:
- Shared package: a state enum `mem_arb_state_t` and a struct `mem_req_t` {is_store, addr, wdata, wstrb}.
- Sub-module `mem_req_slot_buf`: per-slot latch of request plus response data/done flag, instantiated twice.

Test Plan:
- Slot 0 `ld.w` at 0x1000, `addr_ok` on 1st REQ cycle, `data_ok` next cycle with 0xDEADBEEF:
  - `slot_rdata[0]` = 0xDEADBEEF and `slot_done` = 01.
  - `pause_mem` high for exactly 3 cycles, then low 1 cycle.
- Slot 0 store 0x2000 (`wstrb` 0xF) plus slot 1 load 0x2004:
  - `dc_addr` shows 0x2000 then 0x2004, in order.
  - `slot_done` = 11; total 6 cycles.
- `addr_ok` withheld 5 cycles in REQ0:
  - `dc_valid`, `dc_addr`, `dc_wdata` and `dc_wstrb` stay constant throughout.
- `slot_exception` = 01 with both slots valid:
  - No dcache request is issued and `pause_mem` stays 0.
- Flush in WAIT0, `data_ok` 3 cycles later:
  - FSM passes through DRAIN and the data is discarded (`slot_done` = 00).
  - `pause_mem` stays high until `data_ok`, then the FSM returns to IDLE.
- `rst` asserted in WAIT1:
  - All outputs are 0 immediately.
  - After release, a new single load completes normally.
